cmd_decoder: RTL and testbench

CMD_DECODER -- requirements
Module: cmd_decoder

---
 rtl/cmd_decoder_if.sv | 45 ++++
 rtl/cmd_decoder.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_cmd_decoder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_decoder_if.sv
// ============================================================================
// Module      : cmd_decoder_if
// Description : Byte-stream bundle between an Ethernet MAC and the command
//               decoder. Carries the inbound command frame (rx_axis_*) and
//               the outbound response frame (tx_axis_*).
//               slave  : decoder side (consumes rx, produces tx)
//               master : MAC / bench side (produces rx, consumes tx)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmd_decoder_if;
  logic [7:0] rx_axis_tdata;
  logic       rx_axis_tvalid;
  logic       rx_axis_tlast;
  logic       rx_axis_tready;
  logic [7:0] tx_axis_tdata;
  logic       tx_axis_tvalid;
  logic       tx_axis_tlast;
  logic       tx_axis_tready;

  modport slave (
    input  rx_axis_tdata,
    input  rx_axis_tvalid,
    input  rx_axis_tlast,
    output rx_axis_tready,
    output tx_axis_tdata,
    output tx_axis_tvalid,
    output tx_axis_tlast,
    input  tx_axis_tready
  );

  modport master (
    output rx_axis_tdata,
    output rx_axis_tvalid,
    output rx_axis_tlast,
    input  rx_axis_tready,
    input  tx_axis_tdata,
    input  tx_axis_tvalid,
    input  tx_axis_tlast,
    output tx_axis_tready
  );
endinterface

`default_nettype wire

// File: rtl/cmd_decoder.sv
// ============================================================================
// Module      : cmd_decoder
// Description : Ethernet register-access command decoder. Parses inbound
//               frames addressed to this station (or broadcast), writes up to
//               eight 32-bit words into the chirp or FMC register bank, or
//               answers a read with a fixed 60-byte response frame.
// Ports       : gtx_clk_bufg  - sole clock, rising edge
//               gtx_resetn    - asynchronous active-low reset
//               axis          - rx command stream in / tx response stream out
//               gpio_dip_sw   - bit 0 selects the LED display source
//               gpio_led      - command count or last accepted cmd_id[7:0]
//               chirp_regs    - chirp bank C0..C7, Cn at [32n+31:32n]
//               fmc_regs      - FMC bank F0..F7, same packing
//               frame_error   - one-cycle pulse for a rejected frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_decoder #(
  parameter logic [47:0] FPGA_MAC_ADDR             = 48'h5a0102030405,
  parameter logic [31:0] CHIRP_PRF_INT_COUNT_INIT  = 32'h00000000,
  parameter logic [31:0] CHIRP_PRF_FRAC_COUNT_INIT = 32'h927c0000,
  parameter int          SIMULATION                = 0
) (
  input  logic           gtx_clk_bufg,
  input  logic           gtx_resetn,
  cmd_decoder_if.slave   axis,
  input  logic [7:0]     gpio_dip_sw,
  output logic [7:0]     gpio_led,
  output logic [255:0]   chirp_regs,
  output logic [255:0]   fmc_regs,
  output logic           frame_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  localparam logic [5:0] c_tx_last_idx = 6'd59;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_uni;
  logic        r_bc;
  logic        r_bank_c;
  logic        r_bank_f;
  logic        r_op_w;
  logic        r_op_r;
  logic [47:0] r_src;
  logic [31:0] r_id;
  logic [7:0]  r_acc_id;
  logic [7:0]  r_cmd_count;
  logic [31:0] r_stage [8];
  logic [7:0]  r_mask;
  logic        r_commit;
  logic        r_commit_fmc;
  logic [31:0] r_chirp [8];
  logic [31:0] r_fmc   [8];
  logic        r_resp_fmc;
  logic [5:0]  r_tx_idx;
  logic [7:0]  r_tx_tdata;
  logic        r_tx_tvalid;
  logic        r_tx_tlast;
  logic        r_rx_tready;
  logic        r_frame_error;

  logic        w_rx_hs;
  logic        w_tx_hs;
  logic [7:0]  w_rx_byte;
  logic [7:0]  w_mac_byte;
  logic        w_in_dest;
  logic        w_uni_cur;
  logic        w_bc_cur;
  logic [31:0] w_id_next;
  logic [4:0]  w_off;
  logic        w_in_data;
  logic [7:0]  w_bank_ch;
  logic [31:0] w_resp_word [8];
  logic [479:0] w_resp;
  logic [5:0]  w_tx_next;
  logic [7:0]  w_tx_next_byte;
  logic        w_unused_bits;

  assign w_rx_hs   = axis.rx_axis_tvalid & r_rx_tready;
  assign w_tx_hs   = r_tx_tvalid & axis.tx_axis_tready;
  assign w_rx_byte = axis.rx_axis_tdata;

  // Only bit 0 of the DIP switch is meaningful; SIMULATION is reserved.
  assign w_unused_bits = ^{gpio_dip_sw[7:1], (SIMULATION != 0)};

  // Station MAC byte expected at the current destination position.
  always_comb begin
    w_mac_byte = FPGA_MAC_ADDR[47:40];
    case (r_cnt[2:0])
      3'd1:    w_mac_byte = FPGA_MAC_ADDR[39:32];
      3'd2:    w_mac_byte = FPGA_MAC_ADDR[31:24];
      3'd3:    w_mac_byte = FPGA_MAC_ADDR[23:16];
      3'd4:    w_mac_byte = FPGA_MAC_ADDR[15:8];
      3'd5:    w_mac_byte = FPGA_MAC_ADDR[7:0];
      default: w_mac_byte = FPGA_MAC_ADDR[47:40];
    endcase
  end

  // Destination match including the byte currently being accepted, so a
  // frame that ends inside the MAC field is still classified correctly.
  assign w_in_dest = (r_cnt < 8'd6);
  assign w_uni_cur = w_in_dest ? (((r_cnt == 8'd0) ? 1'b1 : r_uni) & (w_rx_byte == w_mac_byte))
                               : r_uni;
  assign w_bc_cur  = w_in_dest ? (((r_cnt == 8'd0) ? 1'b1 : r_bc) & (w_rx_byte == 8'hff))
                               : r_bc;

  // cmd_id including the byte in flight (tlast may land on byte 23).
  always_comb begin
    w_id_next = r_id;
    case (r_cnt)
      8'd20:   w_id_next[7:0]   = w_rx_byte;
      8'd21:   w_id_next[15:8]  = w_rx_byte;
      8'd22:   w_id_next[23:16] = w_rx_byte;
      8'd23:   w_id_next[31:24] = w_rx_byte;
      default: w_id_next        = r_id;
    endcase
  end

  // Data word position; only bytes 24..55 (words 0..7) are staged.
  assign w_off     = r_cnt[4:0] - 5'd24;
  assign w_in_data = (r_cnt >= 8'd24) && (r_cnt < 8'd56);

  // Response frame as one flat vector, byte 0 in the top bits.
  assign w_bank_ch = r_resp_fmc ? 8'h46 : 8'h43;
  assign w_resp[479:288] = {r_src, FPGA_MAC_ADDR, 16'h002e, 16'h0000,
                            w_bank_ch, w_bank_ch, 8'h52, 8'h52,
                            r_id[7:0], r_id[15:8], r_id[23:16], r_id[31:24]};
  assign w_resp[31:0] = 32'h0;

  for (genvar k = 0; k < 8; k++) begin : g_resp
    assign w_resp_word[k] = r_resp_fmc ? r_fmc[k] : r_chirp[k];
    assign w_resp[287-32*k -: 32] = {w_resp_word[k][7:0],   w_resp_word[k][15:8],
                                     w_resp_word[k][23:16], w_resp_word[k][31:24]};
  end

  assign w_tx_next      = r_tx_idx + 6'd1;
  assign w_tx_next_byte = w_resp[(9'd472 - {w_tx_next, 3'b000}) +: 8];

  for (genvar k = 0; k < 8; k++) begin : g_pack
    assign chirp_regs[32*k +: 32] = r_chirp[k];
    assign fmc_regs[32*k +: 32]   = r_fmc[k];
  end

  assign axis.rx_axis_tready = r_rx_tready;
  assign axis.tx_axis_tdata  = r_tx_tdata;
  assign axis.tx_axis_tvalid = r_tx_tvalid;
  assign axis.tx_axis_tlast  = r_tx_tlast;
  assign frame_error         = r_frame_error;
  assign gpio_led            = gpio_dip_sw[0] ? r_cmd_count : r_acc_id;

  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_uni         <= 1'b0;
      r_bc          <= 1'b0;
      r_bank_c      <= 1'b0;
      r_bank_f      <= 1'b0;
      r_op_w        <= 1'b0;
      r_op_r        <= 1'b0;
      r_src         <= 48'h0;
      r_id          <= 32'h0;
      r_acc_id      <= 8'h0;
      r_cmd_count   <= 8'h0;
      r_mask        <= 8'h0;
      r_commit      <= 1'b0;
      r_commit_fmc  <= 1'b0;
      r_resp_fmc    <= 1'b0;
      r_tx_idx      <= 6'd0;
      r_tx_tdata    <= 8'h0;
      r_tx_tvalid   <= 1'b0;
      r_tx_tlast    <= 1'b0;
      r_rx_tready   <= 1'b1;
      r_frame_error <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        r_stage[k] <= 32'h0;
        r_fmc[k]   <= 32'h0;
        r_chirp[k] <= 32'h0;
      end
      r_chirp[0] <= CHIRP_PRF_INT_COUNT_INIT;
      r_chirp[1] <= CHIRP_PRF_FRAC_COUNT_INIT;
    end else begin
      r_frame_error <= 1'b0;
      r_commit      <= 1'b0;

      // Commit the words staged by the previous frame; unsent registers
      // keep their values.
      if (r_commit) begin
        for (int k = 0; k < 8; k++) begin
          if (r_mask[k]) begin
            if (r_commit_fmc) begin
              r_fmc[k] <= r_stage[k];
            end else begin
              r_chirp[k] <= r_stage[k];
            end
          end
        end
      end

      if (w_rx_hs) begin
        if (axis.rx_axis_tlast) begin
          r_cnt <= 8'd0;
        end else if (r_cnt != 8'hff) begin
          r_cnt <= r_cnt + 8'd1;
        end

        if (w_in_dest) begin
          r_uni <= w_uni_cur;
          r_bc  <= w_bc_cur;
        end

        if ((r_cnt >= 8'd6) && (r_cnt < 8'd12)) begin
          r_src <= {r_src[39:0], w_rx_byte};
        end

        case (r_cnt)
          8'd16: begin
            r_bank_c <= (w_rx_byte == 8'h43);
            r_bank_f <= (w_rx_byte == 8'h46);
          end
          8'd17: begin
            r_bank_c <= r_bank_c & (w_rx_byte == 8'h43);
            r_bank_f <= r_bank_f & (w_rx_byte == 8'h46);
          end
          8'd18: begin
            r_op_w <= (w_rx_byte == 8'h57);
            r_op_r <= (w_rx_byte == 8'h52);
          end
          8'd19: begin
            r_op_w <= r_op_w & (w_rx_byte == 8'h57);
            r_op_r <= r_op_r & (w_rx_byte == 8'h52);
          end
          default: ;
        endcase

        if ((r_cnt >= 8'd20) && (r_cnt < 8'd24)) begin
          r_id <= w_id_next;
        end

        // A new frame starts with nothing staged; a word counts as staged
        // only once its fourth byte has arrived.
        if (r_cnt == 8'd0) begin
          r_mask <= 8'h0;
        end else if (w_in_data) begin
          r_stage[w_off[4:2]][{w_off[1:0], 3'b000} +: 8] <= w_rx_byte;
          if (w_off[1:0] == 2'd3) begin
            r_mask[w_off[4:2]] <= 1'b1;
          end
        end

        if (axis.rx_axis_tlast) begin
          r_state <= ST_IDLE;
          if (r_cnt == 8'd0) begin
            r_frame_error <= 1'b1;
          end else if (!(w_uni_cur | w_bc_cur)) begin
            // Not for this station: dropped without an error pulse.
          end else if (r_cnt < 8'd23) begin
            r_frame_error <= 1'b1;
          end else if (!(r_bank_c | r_bank_f) || !(r_op_w | r_op_r)) begin
            r_frame_error <= 1'b1;
          end else begin
            r_cmd_count <= r_cmd_count + 8'd1;
            r_acc_id    <= w_id_next[7:0];
            r_resp_fmc  <= r_bank_f;
            if (r_op_w) begin
              r_commit     <= 1'b1;
              r_commit_fmc <= r_bank_f;
            end else begin
              r_state     <= ST_TX;
              r_rx_tready <= 1'b0;
              r_tx_tvalid <= 1'b1;
              r_tx_tlast  <= 1'b0;
              r_tx_idx    <= 6'd0;
              r_tx_tdata  <= r_src[47:40];
            end
          end
        end else begin
          r_state <= ST_RX;
        end
      end

      if ((r_state == ST_TX) && w_tx_hs) begin
        if (r_tx_idx == c_tx_last_idx) begin
          r_tx_tvalid <= 1'b0;
          r_tx_tlast  <= 1'b0;
          r_tx_tdata  <= 8'h0;
          r_rx_tready <= 1'b1;
          r_state     <= ST_IDLE;
        end else begin
          r_tx_idx   <= w_tx_next;
          r_tx_tdata <= w_tx_next_byte;
          r_tx_tlast <= (w_tx_next == c_tx_last_idx);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_decoder.sv
// ============================================================================
// Module      : tb_cmd_decoder
// Description : Self-checking bench for cmd_decoder. A frame-level reference
//               model classifies each frame, updates model register banks and
//               queues expected response bytes; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cmd_decoder;
  localparam logic [47:0] MAC = 48'h5a0102030405;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   dip;
  logic [7:0]   led;
  logic [255:0] chirp_regs;
  logic [255:0] fmc_regs;
  logic         frame_error;

  always #5 clk = ~clk;

  cmd_decoder_if bus();

  cmd_decoder #(
    .FPGA_MAC_ADDR             (MAC),
    .CHIRP_PRF_INT_COUNT_INIT  (32'h00000000),
    .CHIRP_PRF_FRAC_COUNT_INIT (32'h927c0000),
    .SIMULATION                (0)
  ) dut (
    .gtx_clk_bufg (clk),
    .gtx_resetn   (rst_n),
    .axis         (bus),
    .gpio_dip_sw  (dip),
    .gpio_led     (led),
    .chirp_regs   (chirp_regs),
    .fmc_regs     (fmc_regs),
    .frame_error  (frame_error)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  frame [$];
  logic [8:0]  exp_q [$];
  logic [31:0] m_chirp [8];
  logic [31:0] m_fmc   [8];
  logic [7:0]  m_count;
  logic [7:0]  m_id;
  int          m_err_total = 0;
  int          err_seen = 0;
  logic        hold_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_chirp[k] = 32'h0;
      m_fmc[k]   = 32'h0;
    end
    m_chirp[1] = 32'h927c0000;
    m_count = 8'h0;
    m_id    = 8'h0;
    exp_q.delete();
  endtask

  // 0 = silently dropped, 1 = rejected, 2 = write, 3 = read
  function automatic int classify();
    int n;
    bit uni, bc;
    logic [47:0] mac_v;
    logic [15:0] bank, op;
    n = frame.size();
    mac_v = MAC;
    uni = 1'b1;
    bc  = 1'b1;
    for (int i = 0; i < 6 && i < n; i++) begin
      if (frame[i] != mac_v[47-8*i -: 8]) uni = 1'b0;
      if (frame[i] != 8'hff) bc = 1'b0;
    end
    if (n == 1) return 1;
    if (!(uni || bc)) return 0;
    if (n < 24) return 1;
    bank = {frame[16], frame[17]};
    op   = {frame[18], frame[19]};
    if (bank != 16'h4343 && bank != 16'h4646) return 1;
    if (op == 16'h5757) return 2;
    if (op == 16'h5252) return 3;
    return 1;
  endfunction

  task automatic model_apply(input int kind);
    int n;
    bit fmc;
    logic [31:0] w;
    logic [47:0] mac_v;
    n = frame.size();
    mac_v = MAC;
    if (kind == 1) m_err_total++;
    if (kind >= 2) begin
      fmc = (frame[16] == 8'h46);
      m_count = m_count + 8'd1;
      m_id = frame[20];
      if (kind == 2) begin
        for (int k = 0; k < 8; k++) begin
          if (n >= 28 + 4*k) begin
            w = {frame[27+4*k], frame[26+4*k], frame[25+4*k], frame[24+4*k]};
            if (fmc) m_fmc[k] = w; else m_chirp[k] = w;
          end
        end
      end else begin
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, frame[6+i]});
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, mac_v[47-8*i -: 8]});
        exp_q.push_back(9'h000); exp_q.push_back(9'h02e);
        exp_q.push_back(9'h000); exp_q.push_back(9'h000);
        for (int i = 16; i < 24; i++) exp_q.push_back({1'b0, frame[i]});
        for (int k = 0; k < 8; k++) begin
          w = fmc ? m_fmc[k] : m_chirp[k];
          for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, w[8*j +: 8]});
        end
        exp_q.push_back(9'h000); exp_q.push_back(9'h000);
        exp_q.push_back(9'h000); exp_q.push_back(9'h100);
      end
    end
  endtask

  // ---------------- frame building ----------------
  task automatic push_be(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) frame.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input logic [47:0] dest, input logic [15:0] bank, input logic [15:0] op,
                       input logic [31:0] id, input int nwords, input int extra);
    frame.delete();
    push_be({16'h0, dest}, 6);
    push_be({$urandom, $urandom}, 6);
    push_be(64'h0026, 2);
    push_be(64'h0000, 2);
    push_be({48'h0, bank}, 2);
    push_be({48'h0, op}, 2);
    push_be({32'h0, id[7:0], id[15:8], id[23:16], id[31:24]}, 4);
    for (int k = 0; k < nwords; k++) push_be({32'h0, $urandom}, 4);
    for (int k = 0; k < extra; k++) push_be({56'h0, 8'($urandom)}, 1);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus.rx_axis_tvalid = 1'b0;
    bus.rx_axis_tlast  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Sends the frame; when abort_at >= 0 a reset is applied instead of
  // that byte and the rest of the frame is abandoned.
  task automatic send_frame(input int abort_at);
    int kind, n, guard;
    logic hs;
    kind = classify();
    n = frame.size();
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      bus.rx_axis_tvalid = 1'b1;
      bus.rx_axis_tdata  = frame[i];
      bus.rx_axis_tlast  = (i == n - 1);
      guard = 0;
      forever begin
        @(negedge clk);
        hs = bus.rx_axis_tready;
        @(posedge clk);
        #1;
        if (hs) break;
        guard++;
        if (guard > 3000) begin
          fail_now("rx_accept_timeout");
          break;
        end
      end
      bus.rx_axis_tvalid = 1'b0;
      bus.rx_axis_tlast  = 1'b0;
    end
    model_apply(kind);
    @(negedge clk);
    check("frame_error_pulse", {63'h0, frame_error}, {63'h0, (kind == 1)});
    check("tx_start", {63'h0, bus.tx_axis_tvalid}, {63'h0, (kind == 3)});
  endtask

  task automatic finish_frame();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.tx_axis_tvalid) && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) fail_now("tx_drain_timeout");
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      check("chirp_reg", {32'h0, chirp_regs[32*k +: 32]}, {32'h0, m_chirp[k]});
      check("fmc_reg", {32'h0, fmc_regs[32*k +: 32]}, {32'h0, m_fmc[k]});
    end
    dip = 8'h01;
    #1;
    check("led_cmd_count", {56'h0, led}, {56'h0, m_count});
    dip = 8'h00;
    #1;
    check("led_cmd_id", {56'h0, led}, {56'h0, m_id});
    check("frame_error_total", 64'(err_seen), 64'(m_err_total));
    check("rx_ready_idle", {63'h0, bus.rx_axis_tready}, 64'h1);
  endtask

  // ---------------- tx ready generator ----------------
  initial begin
    bus.tx_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) bus.tx_axis_tready = 1'b0;
      else bus.tx_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic       prev_stall;
    logic [8:0] prev;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev = 9'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("tx_hold", {54'h0, bus.tx_axis_tvalid, bus.tx_axis_tlast, bus.tx_axis_tdata},
                {54'h0, 1'b1, prev});
        end
        if (bus.tx_axis_tvalid && bus.tx_axis_tready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got %h expected none", bus.tx_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", {55'h0, bus.tx_axis_tlast, bus.tx_axis_tdata}, {55'h0, e});
          end
        end
        prev_stall = bus.tx_axis_tvalid && !bus.tx_axis_tready;
        prev = {bus.tx_axis_tlast, bus.tx_axis_tdata};
        if (frame_error) err_seen++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [47:0] dest;
    logic [15:0] bank, op;
    int r;

    dip = 8'h00;
    bus.rx_axis_tvalid = 1'b0;
    bus.rx_axis_tlast  = 1'b0;
    bus.rx_axis_tdata  = 8'h00;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_c1", {32'h0, chirp_regs[63:32]}, 64'h927c0000);
    check("rst_c0", {32'h0, chirp_regs[31:0]}, 64'h0);
    check("rst_tx_valid", {63'h0, bus.tx_axis_tvalid}, 64'h0);
    check("rst_rx_ready", {63'h0, bus.rx_axis_tready}, 64'h1);
    check("rst_frame_error", {63'h0, frame_error}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Known write frame, first to a foreign MAC, then to the station.
    for (int pass = 0; pass < 2; pass++) begin
      frame.delete();
      push_be((pass == 0) ? 64'h5a0102030406 : 64'h5a0102030405, 6);
      push_be(64'h985aebdb066f, 6);
      push_be(64'h0026, 2);
      push_be(64'h0000, 2);
      push_be(64'h43435757, 4);
      push_be(64'h27470000, 4);
      push_be(64'h00000000, 4); push_be(64'hf6000000, 4);
      push_be(64'hc8000000, 4); push_be(64'h00030000, 4);
      push_be(64'h01000000, 4); push_be(64'h00100000, 4);
      push_be(64'h05000000, 4);
      send_frame(-1);
      finish_frame();
    end
    check("known_c1", {32'h0, chirp_regs[63:32]}, 64'h000000f6);
    check("known_c5", {32'h0, chirp_regs[191:160]}, 64'h00001000);
    check("known_c6", {32'h0, chirp_regs[223:192]}, 64'h00000005);
    dip = 8'hff;
    #1;
    check("known_led", {56'h0, led}, 64'h1);
    dip = 8'h00;

    // Read with the response stalled for 32 cycles.
    frame.delete();
    push_be(64'h5a0102030405, 6);
    push_be(64'ha45e60ee9f35, 6);
    push_be(64'h000e, 2);
    push_be(64'h0100, 2);
    push_be(64'h43435252, 4);
    push_be(64'h04000000, 4);
    push_be(64'hefbeedfe, 4);
    hold_ready = 1'b1;
    send_frame(-1);
    repeat (32) @(posedge clk);
    #1;
    check("stall_valid", {63'h0, bus.tx_axis_tvalid}, 64'h1);
    check("stall_rx_ready", {63'h0, bus.rx_axis_tready}, 64'h0);
    hold_ready = 1'b0;
    finish_frame();

    // FMC bank write of all eight words then read back; bad opcode.
    build(MAC, 16'h4646, 16'h5757, 32'h11223344, 8, 0);
    send_frame(-1); finish_frame();
    build(MAC, 16'h4646, 16'h5252, 32'h55, 0, 0);
    send_frame(-1); finish_frame();
    build(MAC, 16'h4343, 16'h5858, 32'h66, 2, 0);
    send_frame(-1); finish_frame();

    // Short frames and boundaries.
    frame.delete(); push_be(64'h5a, 1);
    send_frame(-1); finish_frame();
    build(MAC, 16'h4343, 16'h5757, 32'h1, 0, 0);
    while (frame.size() > 11) void'(frame.pop_back());
    send_frame(-1); finish_frame();
    build(MAC, 16'h4343, 16'h5757, 32'h2, 0, 0);
    void'(frame.pop_back());
    send_frame(-1); finish_frame();
    build(MAC, 16'h4343, 16'h5757, 32'h3, 0, 0);
    send_frame(-1); finish_frame();
    build(48'hffffffffffff, 16'h4343, 16'h5757, 32'h4, 10, 3);
    send_frame(-1); finish_frame();
    build(MAC, 16'h4646, 16'h5757, 32'h5, 3, 2);
    send_frame(-1); finish_frame();
    build(MAC, 16'h4343, 16'h5757, 32'h6, 69, 0);
    send_frame(-1); finish_frame();

    // Reset mid-write, then a complete frame.
    build(MAC, 16'h4646, 16'h5757, 32'h7, 8, 0);
    send_frame(30); finish_frame();
    build(MAC, 16'h4646, 16'h5757, 32'h8, 4, 0);
    send_frame(-1); finish_frame();

    // Reset mid-response.
    build(MAC, 16'h4646, 16'h5252, 32'h9, 0, 0);
    hold_ready = 1'b1;
    send_frame(-1);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    hold_ready = 1'b0;
    finish_frame();
    build(MAC, 16'h4343, 16'h5252, 32'ha, 0, 0);
    send_frame(-1); finish_frame();

    // Randomised frames.
    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) dest = {$urandom, $urandom};
      else if (r == 1) dest = 48'hffffffffffff;
      else if (r == 2) dest = MAC ^ 48'h000000000100;
      else dest = MAC;
      r = $urandom_range(0, 6);
      bank = (r == 0) ? 16'h4344 : ((r < 4) ? 16'h4343 : 16'h4646);
      r = $urandom_range(0, 6);
      op = (r == 0) ? 16'h5752 : ((r < 4) ? 16'h5757 : 16'h5252);
      build(dest, bank, op, $urandom, $urandom_range(0, 10), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(1, 23);
        while (frame.size() > r) void'(frame.pop_back());
      end
      send_frame(-1);
      finish_frame();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
